// File: rtl/line_draw_sched_if.sv
// line_draw_sched_if
//   Groups the line-queue head and the framebuffer write port used by line_draw_sched.
//   master : the sequencer (pops the queue, issues pixel writes)
//   slave  : the queue / framebuffer side
//   Signals:
//     q_empty, q_startX, q_startY, q_endX, q_endY, q_color  head-of-queue line (to master)
//     q_read                                               1-cycle pop strobe (from master)
//     fb_we, fb_x, fb_y, fb_color                          pixel write request (from master)
//     fb_ready                                             write accepted when fb_we && fb_ready
interface line_draw_sched_if;
  logic        q_empty;
  logic [10:0] q_startX;
  logic [10:0] q_startY;
  logic [10:0] q_endX;
  logic [10:0] q_endY;
  logic [2:0]  q_color;
  logic        q_read;
  logic        fb_we;
  logic [10:0] fb_x;
  logic [10:0] fb_y;
  logic [2:0]  fb_color;
  logic        fb_ready;

  modport master (
    input  q_empty, q_startX, q_startY, q_endX, q_endY, q_color, fb_ready,
    output q_read, fb_we, fb_x, fb_y, fb_color
  );

  modport slave (
    output q_empty, q_startX, q_startY, q_endX, q_endY, q_color, fb_ready,
    input  q_read, fb_we, fb_x, fb_y, fb_color
  );
endinterface

// File: rtl/line_draw_sched.sv
// line_draw_sched
//   Frame sequencer between the AVG line queue and the framebuffer write port.
//   Each frame clears the framebuffer in row-major order, then pops queued vectors
//   one at a time and rasterises them with Bresenham into single-pixel writes.
//   frame_done pulses once the AVG has halted and the queue is drained.
//   Ports:
//     clk_in       system clock (queue and framebuffer share it)
//     rst_b        asynchronous active-low reset
//     frame_start  1-cycle pulse, start a frame; while busy it is remembered as pending
//     avg_halt     AVG halted, no more vectors will arrive
//     bus          line_draw_sched_if.master (queue head + framebuffer write port)
//     busy         high in every state except IDLE
//     frame_done   1-cycle pulse on frame completion
//   Build option:
//     LDS_CLIP_EN  when defined, off-screen line pixels are skipped (no write, no stall)
//
//   state  | meaning
//   IDLE   | waiting for frame_start or a pending request
//   CLEAR  | sweeping CLEAR_COLOR over every visible pixel
//   FETCH  | popping the next line, or finishing when the AVG has halted
//   DRAW   | stepping Bresenham, one pixel per accepted write
//   DONE   | one-cycle frame_done pulse
module line_draw_sched #(
  parameter int         SCREEN_W    = 640,
  parameter int         SCREEN_H    = 480,
  parameter logic [2:0] CLEAR_COLOR = 3'd0
) (
  input  logic              clk_in,
  input  logic              rst_b,
  input  logic              frame_start,
  input  logic              avg_halt,
  line_draw_sched_if.master bus,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_DRAW,
    ST_DONE
  } state_t;

  localparam logic [10:0] X_LAST = 11'(SCREEN_W - 1);
  localparam logic [10:0] Y_LAST = 11'(SCREEN_H - 1);

  state_t state, state_nxt;

  logic              pending;
  logic [10:0]       cx, cy;
  logic [10:0]       px, py, px1, py1;
  logic [2:0]        pcol;
  logic signed [12:0] dx, dy, err;
  logic              sx_neg, sy_neg;

  // line setup from the queue head
  logic signed [12:0] f_ddx, f_ddy, f_adx, f_ndy;

  assign f_ddx = $signed({2'b00, bus.q_endX}) - $signed({2'b00, bus.q_startX});
  assign f_ddy = $signed({2'b00, bus.q_endY}) - $signed({2'b00, bus.q_startY});
  assign f_adx = f_ddx[12] ? -f_ddx : f_ddx;
  assign f_ndy = f_ddy[12] ? f_ddy : -f_ddy;

  // Bresenham step; both decisions use the pre-update error term
  logic signed [13:0] e2, dx_w, dy_w;
  logic               step_x, step_y;
  logic signed [12:0] err_nxt;

  assign e2      = {err, 1'b0};
  assign dx_w    = {dx[12], dx};
  assign dy_w    = {dy[12], dy};
  assign step_x  = (e2 >= dy_w);
  assign step_y  = (e2 <= dx_w);
  assign err_nxt = err + (step_x ? dy : 13'sd0) + (step_y ? dx : 13'sd0);

  logic pix_vis, draw_accept, draw_last, clear_last, go;

`ifdef LDS_CLIP_EN
  // an off-screen pixel is treated as accepted immediately so stepping never stalls
  assign pix_vis = ({1'b0, px} < 12'(SCREEN_W)) && ({1'b0, py} < 12'(SCREEN_H));
`else
  assign pix_vis = 1'b1;
`endif

  assign draw_accept = bus.fb_ready || !pix_vis;
  assign draw_last   = (px == px1) && (py == py1);
  assign clear_last  = (cx == X_LAST) && (cy == Y_LAST);
  assign go          = frame_start || pending;

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b1;
    frame_done   = 1'b0;
    bus.q_read   = 1'b0;
    bus.fb_we    = 1'b0;
    bus.fb_x     = 11'd0;
    bus.fb_y     = 11'd0;
    bus.fb_color = 3'd0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (go) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        bus.fb_we    = 1'b1;
        bus.fb_x     = cx;
        bus.fb_y     = cy;
        bus.fb_color = CLEAR_COLOR;
        if (bus.fb_ready && clear_last) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (!bus.q_empty) begin
          bus.q_read = 1'b1;
          state_nxt  = ST_DRAW;
        end else if (avg_halt) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DRAW: begin
        bus.fb_we    = pix_vis;
        bus.fb_x     = px;
        bus.fb_y     = py;
        bus.fb_color = pcol;
        if (draw_accept && draw_last) state_nxt = ST_FETCH;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_b) begin
    if (!rst_b) begin
      pending <= 1'b0;
      cx      <= 11'd0;
      cy      <= 11'd0;
      px      <= 11'd0;
      py      <= 11'd0;
      px1     <= 11'd0;
      py1     <= 11'd0;
      pcol    <= 3'd0;
      dx      <= 13'sd0;
      dy      <= 13'sd0;
      err     <= 13'sd0;
      sx_neg  <= 1'b0;
      sy_neg  <= 1'b0;
    end else begin
      // requests arriving while busy collapse into a single pending frame
      if (state == ST_IDLE) begin
        if (go) pending <= 1'b0;
      end else if (frame_start) begin
        pending <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (go) begin
            cx <= 11'd0;
            cy <= 11'd0;
          end
        end
        ST_CLEAR: begin
          if (bus.fb_ready) begin
            if (cx == X_LAST) begin
              cx <= 11'd0;
              cy <= (cy == Y_LAST) ? 11'd0 : cy + 11'd1;
            end else begin
              cx <= cx + 11'd1;
            end
          end
        end
        ST_FETCH: begin
          if (!bus.q_empty) begin
            px     <= bus.q_startX;
            py     <= bus.q_startY;
            px1    <= bus.q_endX;
            py1    <= bus.q_endY;
            pcol   <= bus.q_color;
            dx     <= f_adx;
            dy     <= f_ndy;
            err    <= f_adx + f_ndy;
            sx_neg <= f_ddx[12];
            sy_neg <= f_ddy[12];
          end
        end
        ST_DRAW: begin
          if (draw_accept && !draw_last) begin
            err <= err_nxt;
            if (step_x) px <= sx_neg ? px - 11'd1 : px + 11'd1;
            if (step_y) py <= sy_neg ? py - 11'd1 : py + 11'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_draw_sched.sv
module tb_line_draw_sched;
  localparam int W = 32;
  localparam int H = 24;

  logic clk_in = 1'b0;
  logic rst_b = 1'b0;
  logic frame_start = 1'b0;
  logic avg_halt = 1'b0;
  logic busy, frame_done;

  line_draw_sched_if bus ();

  line_draw_sched #(.SCREEN_W(W), .SCREEN_H(H), .CLEAR_COLOR(3'd0)) dut (
    .clk_in      (clk_in),
    .rst_b       (rst_b),
    .frame_start (frame_start),
    .avg_halt    (avg_halt),
    .bus         (bus.master),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int x0; int y0; int x1; int y1; int c;
  } line_t;

  line_t lq[$];
  int    exp_q[$];
  int    obs_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    ready_pct = 100;
  bit    pop_pend = 0;
  int    n_reads = 0;
  int    n_done = 0;
  int    frame_acc = 0;
  int    cyc = 0;
  int    last_clr_cyc = 0;
  int    done_cyc = 0;
  bit    stall_prev = 0;
  longint stall_val = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pack(input int x, input int y, input int c);
    return (x << 16) | (y << 4) | c;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // reference rasteriser on plain integers
  function automatic void ref_line(input line_t l);
    int x, y, dx, dy, sx, sy, err, e2;
    x = l.x0; y = l.y0;
    dx = iabs(l.x1 - l.x0);
    dy = -iabs(l.y1 - l.y0);
    sx = (l.x0 < l.x1) ? 1 : -1;
    sy = (l.y0 < l.y1) ? 1 : -1;
    err = dx + dy;
    forever begin
`ifdef LDS_CLIP_EN
      if (x < W && y < H) exp_q.push_back(pack(x, y, l.c));
`else
      exp_q.push_back(pack(x, y, l.c));
`endif
      if (x == l.x1 && y == l.y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  function automatic void exp_clear();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        exp_q.push_back(pack(xx, yy, 0));
  endfunction

  function automatic void exp_frame();
    exp_clear();
    foreach (lq[i]) ref_line(lq[i]);
  endfunction

  function automatic void add_line(input int x0, input int y0, input int x1, input int y1, input int c);
    line_t l;
    l.x0 = x0; l.y0 = y0; l.x1 = x1; l.y1 = y1; l.c = c;
    lq.push_back(l);
  endfunction

  // queue head and fb_ready driver
  initial begin
    bus.q_empty = 1'b1; bus.q_startX = '0; bus.q_startY = '0;
    bus.q_endX = '0; bus.q_endY = '0; bus.q_color = '0; bus.fb_ready = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (pop_pend) begin
        if (lq.size() > 0) void'(lq.pop_front());
        pop_pend = 0;
      end
      bus.q_empty = (lq.size() == 0);
      if (lq.size() > 0) begin
        bus.q_startX = 11'(lq[0].x0); bus.q_startY = 11'(lq[0].y0);
        bus.q_endX   = 11'(lq[0].x1); bus.q_endY   = 11'(lq[0].y1);
        bus.q_color  = 3'(lq[0].c);
      end
      bus.fb_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // monitor, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk_in);
      cyc++;
      if (bus.q_read) begin
        chk("q_read_when_empty", bus.q_empty, 0);
        n_reads++;
        pop_pend = 1;
      end
      if (stall_prev)
        chk("stall_stable", {bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color}, stall_val);
      stall_prev = bus.fb_we && !bus.fb_ready;
      stall_val  = {bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color};
      if (bus.fb_we && bus.fb_ready) begin
        obs_q.push_back(pack(bus.fb_x, bus.fb_y, bus.fb_color));
        frame_acc++;
        if (frame_acc == W * H) last_clr_cyc = cyc;
      end
      if (frame_done) begin
        done_cyc = cyc;
        n_done++;
        frame_acc = 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk_in); #1 frame_start = 1'b1;
    @(posedge clk_in); #1 frame_start = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt);
    int i;
    for (i = 0; i < 8000 && n_done == start_cnt; i++) @(negedge clk_in);
    if (n_done == start_cnt) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_pix_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_pix"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int d0, r0, nl, spec_px[6];

    // reset values
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_fb_we", bus.fb_we, 0);
    chk("rst_q_read", bus.q_read, 0);
    chk("rst_fb_xy", {bus.fb_x, bus.fb_y, bus.fb_color}, 0);
    rst_b = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 chk("idle_busy", busy, 0);

    // frame 1: full-speed clear plus the reference line
    avg_halt = 1'b1;
    ready_pct = 100;
    add_line(10, 10, 15, 12, 5);
    add_line(3, 7, 9, 2, 2);
    nl = lq.size();
    exp_frame();
    d0 = n_done; r0 = n_reads;
    pulse_start();
    wait_done(d0);
    chk("f1_reads", n_reads - r0, nl);
    spec_px = '{pack(10,10,5), pack(11,10,5), pack(12,11,5),
                pack(13,11,5), pack(14,12,5), pack(15,12,5)};
    for (int i = 0; i < 6; i++)
      if (obs_q.size() > W * H + i) chk("spec_line_px", obs_q[W * H + i], spec_px[i]);
      else chk("spec_line_missing", obs_q.size(), W * H + 6);
    compare_stream("f1");

    // frame 2: stalls, degenerate, negative and random lines
    ready_pct = 60;
    add_line(20, 20, 20, 20, 1);
    add_line(30, 5, 30, 0, 3);
    add_line(5, 5, 0, 0, 6);
    add_line(28, 3, 40, 3, 7);
    for (int i = 0; i < 6; i++)
      add_line($urandom_range(40), $urandom_range(30), $urandom_range(40), $urandom_range(30),
               $urandom_range(7));
    nl = lq.size();
    exp_frame();
    d0 = n_done; r0 = n_reads;
    pulse_start();
    wait_done(d0);
    chk("f2_reads", n_reads - r0, nl);
    compare_stream("f2");

    // frame 3: empty queue, halt already set -> frame_done two cycles after last clear
    ready_pct = 100;
    exp_frame();
    d0 = n_done;
    pulse_start();
    wait_done(d0);
    chk("done_latency", done_cyc - last_clr_cyc, 2);
    @(negedge clk_in);
    chk("busy_after_done", busy, 0);
    compare_stream("f3");

    // frame 4: frame_start twice mid-draw -> exactly one following frame
    ready_pct = 80;
    add_line(0, 0, 30, 20, 4);
    add_line(31, 0, 0, 23, 2);
    exp_frame();
    d0 = n_done;
    pulse_start();
    for (int i = 0; i < 4000 && frame_acc <= W * H + 5; i++) @(negedge clk_in);
    chk("f4_reached_draw", frame_acc > W * H + 5, 1);
    pulse_start();
    pulse_start();
    wait_done(d0);
    @(negedge clk_in);
    chk("pend_idle_gap", busy, 0);
    @(negedge clk_in);
    chk("pend_clear_busy", busy, 1);
    chk("pend_clear_we", bus.fb_we, 1);
    chk("pend_clear_xy", {bus.fb_x, bus.fb_y}, 0);
    exp_clear();
    wait_done(d0 + 1);
    compare_stream("f45");
    repeat (10) @(negedge clk_in);
    chk("pend_collapsed", n_done, d0 + 2);
    chk("idle_after_pend", busy, 0);

    // async reset in the middle of a line
    ready_pct = 100;
    add_line(0, 1, 31, 1, 3);
    d0 = n_done;
    pulse_start();
    for (int i = 0; i < 4000 && frame_acc <= W * H + 3; i++) @(negedge clk_in);
    #2 rst_b = 1'b0;
    #1;
    stall_prev = 0;
    chk("abort_busy", busy, 0);
    chk("abort_fb_we", bus.fb_we, 0);
    lq.delete();
    pop_pend = 0;
    frame_acc = 0;
    repeat (2) @(posedge clk_in);
    #1 rst_b = 1'b1;
    repeat (5) @(negedge clk_in);
    chk("abort_stays_idle", busy, 0);
    chk("abort_no_done", n_done, d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
